// File: rtl/fetch_unit.sv
// WISC-16 instruction fetch stage with IF/ID register and one-entry skid buffer.
// Issues word reads over a variable-latency handshake and handles stall, redirect and HLT.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              imem_valid,
  output logic [15:0]       instr_o,
  output logic [3:0]        opcode_o,
  output logic [ADDR_W-1:0] pc_plus1_o,
  output logic              instr_valid_o,
  output logic              halted_o
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [3:0]        OP_HLT = 4'hF;
  localparam logic [ADDR_W-1:0] ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc1_q, pc1_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              skid_full_q, skid_full_d;
  logic [15:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc1_q, skid_pc1_d;
  logic              squash_q, squash_d;

  logic              issue;
  logic              accept;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_q + ONE;

  // A redirect in REQ suppresses the read so no stale request is left in flight.
  assign issue  = (state_q == S_REQ) && !skid_full_q && !redirect_i;
  assign accept = (state_q == S_WAIT) && imem_valid && !squash_q;

  assign imem_rd   = !rst && (issue || (state_q == S_WAIT));
  assign imem_addr = (state_q == S_WAIT) ? addr_q : pc_q;

  assign instr_o       = instr_q;
  assign opcode_o      = instr_q[15:12];
  assign pc_plus1_o    = pc1_q;
  assign instr_valid_o = valid_q;
  assign halted_o      = halted_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    pc1_d        = pc1_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    skid_full_d  = skid_full_q;
    skid_instr_d = skid_instr_q;
    skid_pc1_d   = skid_pc1_q;
    squash_d     = squash_q;

    if (redirect_i) begin
      pc_d        = redirect_pc_i;
      valid_d     = 1'b0;
      skid_full_d = 1'b0;
      halted_d    = 1'b0;
      // An in-flight read must still complete; its data is dropped.
      if ((state_q == S_WAIT) && !imem_valid) begin
        state_d  = S_WAIT;
        squash_d = 1'b1;
      end else begin
        state_d  = S_REQ;
        squash_d = 1'b0;
      end
    end else begin
      if (!stall_i) begin
        if (skid_full_q) begin
          instr_d     = skid_instr_q;
          pc1_d       = skid_pc1_q;
          valid_d     = 1'b1;
          skid_full_d = 1'b0;
        end else if (accept) begin
          instr_d = imem_data;
          pc1_d   = pc_inc;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_full_d  = 1'b1;
        skid_instr_d = imem_data;
        skid_pc1_d   = pc_inc;
      end

      unique case (1'b1)
        state_q == S_REQ: begin
          if (issue) begin
            state_d = S_WAIT;
            addr_d  = pc_q;
          end
        end
        state_q == S_WAIT: begin
          if (imem_valid) begin
            squash_d = 1'b0;
            if (squash_q) begin
              state_d = S_REQ;
            end else begin
              pc_d = pc_inc;
              if (imem_data[15:12] == OP_HLT) begin
                state_d  = S_HALT;
                halted_d = 1'b1;
              end else begin
                state_d = S_REQ;
              end
            end
          end
        end
        state_q == S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      instr_q      <= 16'h0000;
      pc1_q        <= '0;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      skid_full_q  <= 1'b0;
      skid_instr_q <= 16'h0000;
      skid_pc1_q   <= '0;
      squash_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      pc1_q        <= pc1_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      skid_full_q  <= skid_full_d;
      skid_instr_q <= skid_instr_d;
      skid_pc1_q   <= skid_pc1_d;
      squash_q     <= squash_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run
// checked against a program-order model of the fetched instruction stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [15:0] instr_o;
  logic [3:0]  opcode_o;
  logic [15:0] pc_plus1_o;
  logic        instr_valid_o;
  logic        halted_o;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_valid(imem_valid),
    .instr_o(instr_o), .opcode_o(opcode_o),
    .pc_plus1_o(pc_plus1_o), .instr_valid_o(instr_valid_o),
    .halted_o(halted_o)
  );

  logic [15:0] mem [0:65535];
  bit          m_busy;
  int          m_cnt;
  logic [15:0] m_addr;
  int          lat;
  bit          lat_rand;
  bit          hold_viol;
  logic [15:0] req_log [$];
  int          errors = 0;
  int          checks = 0;

  // One clock: drive inputs at negedge, let outputs settle, advance memory model.
  task automatic tick(input logic s, input logic r,
                      input logic [15:0] rp, input logic rs);
    @(negedge clk);
    stall_i = s; redirect_i = r; redirect_pc_i = rp; rst = rs;
    if (!rs && m_busy && m_cnt == 0) begin
      imem_valid = 1'b1; imem_data = mem[m_addr];
    end else begin
      imem_valid = 1'b0; imem_data = 16'($urandom);
    end
    #1;
    hold_viol = 1'b0;
    if (rs) m_busy = 1'b0;
    else if (m_busy) begin
      hold_viol = !(imem_rd === 1'b1 && imem_addr === m_addr);
      if (imem_valid) m_busy = 1'b0;
      else m_cnt--;
    end else if (imem_rd === 1'b1) begin
      m_busy = 1'b1;
      m_addr = imem_addr;
      m_cnt = (lat_rand ? int'($urandom_range(4, 1)) : lat) - 1;
      req_log.push_back(imem_addr);
    end
  endtask

  task automatic do_reset();
    m_busy = 1'b0;
    req_log.delete();
    tick(0, 0, 16'h0, 1);
    tick(0, 0, 16'h0, 1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
  endtask

  task automatic test_reset();
    lat_rand = 0; lat = 1;
    do_reset();
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
    checks++; if (instr_o !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", instr_o); end
    checks++; if (pc_plus1_o !== 16'h0000) begin errors++; $display("FAIL reset_pc1: got %h want 0000", pc_plus1_o); end
    checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted_o); end
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", imem_rd); end
    tick(0, 0, 16'h0, 0);
    checks++; if ({imem_rd, imem_addr} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL reset_first_req: got rd=%b addr=%h want rd=1 addr=0000", imem_rd, imem_addr); end
  endtask

  task automatic test_sequential();
    clear_mem();
    mem[0] = 16'h0123; mem[1] = 16'h8456; mem[2] = 16'h1111;
    lat_rand = 0; lat = 1;
    do_reset();
    tick(0, 0, 16'h0, 0);
    tick(0, 0, 16'h0, 0);
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL seq_empty: got %b want 0", instr_valid_o); end
    tick(0, 0, 16'h0, 0);
    checks++; if ({instr_valid_o, instr_o, pc_plus1_o} !== {1'b1, 16'h0123, 16'h0001}) begin errors++; $display("FAIL seq_first: got v=%b %h pc1=%h want v=1 0123 pc1=0001", instr_valid_o, instr_o, pc_plus1_o); end
    tick(0, 0, 16'h0, 0);
    tick(0, 0, 16'h0, 0);
    checks++; if ({instr_o, opcode_o, pc_plus1_o} !== {16'h8456, 4'h8, 16'h0002}) begin errors++; $display("FAIL seq_second: got %h op=%h pc1=%h want 8456 op=8 pc1=0002", instr_o, opcode_o, pc_plus1_o); end
    checks++; if (req_log.size() != 3 || {req_log[0], req_log[1], req_log[2]} !== 48'h0000_0001_0002) begin errors++; $display("FAIL seq_addrs: got %p want 0,1,2", req_log); end
  endtask

  task automatic test_stall();
    clear_mem();
    mem[0] = 16'h0123; mem[1] = 16'h8456; mem[2] = 16'h1111;
    lat_rand = 0; lat = 1;
    do_reset();
    tick(0, 0, 16'h0, 0);
    tick(0, 0, 16'h0, 0);
    tick(0, 0, 16'h0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 16'h0, 0);
      checks++; if (instr_o !== 16'h0123) begin errors++; $display("FAIL stall_hold: got %h want 0123", instr_o); end
      if (i > 0) begin
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL stall_no_req: got %b want 0", imem_rd); end
      end
    end
    tick(0, 0, 16'h0, 0);
    checks++; if (instr_o !== 16'h0123) begin errors++; $display("FAIL stall_release: got %h want 0123", instr_o); end
    tick(0, 0, 16'h0, 0);
    checks++; if ({instr_valid_o, instr_o, pc_plus1_o} !== {1'b1, 16'h8456, 16'h0002}) begin errors++; $display("FAIL stall_skid_out: got v=%b %h pc1=%h want v=1 8456 pc1=0002", instr_valid_o, instr_o, pc_plus1_o); end
    checks++; if (req_log.size() != 3 || {req_log[0], req_log[1], req_log[2]} !== 48'h0000_0001_0002) begin errors++; $display("FAIL stall_addrs: got %p want 0,1,2", req_log); end
  endtask

  task automatic test_squash();
    int n;
    bit seen;
    clear_mem();
    mem[0] = 16'h0123; mem[1] = 16'h8456; mem[2] = 16'h2222; mem[16'h40] = 16'h3abc;
    lat_rand = 0; lat = 3;
    do_reset();
    n = 0;
    while (req_log.size() < 3 && n < 40) begin tick(0, 0, 16'h0, 0); n++; end
    checks++; if (req_log.size() < 3) begin errors++; $display("FAIL squash_timeout_req2: got %0d reqs want 3", req_log.size()); end
    tick(0, 1, 16'h0040, 0);
    checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL squash_addr_hold: got %h want 0002", imem_addr); end
    n = 0; seen = 0;
    while (req_log.size() < 4 && n < 20) begin
      tick(0, 0, 16'h0, 0); n++;
      if (instr_valid_o) seen = 1;
    end
    checks++; if (req_log.size() != 4 || req_log[3] !== 16'h0040) begin errors++; $display("FAIL squash_next_addr: got %p want 4th=0040", req_log); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL squash_valid_low: got %b want 0", seen); end
    n = 0;
    while (!instr_valid_o && n < 20) begin tick(0, 0, 16'h0, 0); n++; end
    checks++; if ({instr_valid_o, instr_o, pc_plus1_o} !== {1'b1, 16'h3abc, 16'h0041}) begin errors++; $display("FAIL squash_target: got v=%b %h pc1=%h want v=1 3abc pc1=0041", instr_valid_o, instr_o, pc_plus1_o); end
  endtask

  task automatic test_halt();
    int n;
    clear_mem();
    mem[0] = 16'h0123; mem[1] = 16'h8456; mem[2] = 16'hF000; mem[16'h10] = 16'h5555;
    lat_rand = 0; lat = 1;
    do_reset();
    n = 0;
    while (!(instr_valid_o && instr_o == 16'hF000) && n < 30) begin tick(0, 0, 16'h0, 0); n++; end
    checks++; if ({instr_valid_o, instr_o, opcode_o, pc_plus1_o} !== {1'b1, 16'hF000, 4'hF, 16'h0003}) begin errors++; $display("FAIL halt_word: got v=%b %h op=%h pc1=%h want v=1 F000 op=F pc1=0003", instr_valid_o, instr_o, opcode_o, pc_plus1_o); end
    checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", halted_o); end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 16'h0, 0);
      checks++; if ({imem_rd, halted_o} !== 2'b01) begin errors++; $display("FAIL halt_idle: got rd=%b halted=%b want rd=0 halted=1", imem_rd, halted_o); end
    end
    tick(0, 1, 16'h0010, 0);
    tick(0, 0, 16'h0, 0);
    checks++; if ({halted_o, imem_rd, imem_addr} !== {1'b0, 1'b1, 16'h0010}) begin errors++; $display("FAIL halt_resume: got halted=%b rd=%b addr=%h want 0 1 0010", halted_o, imem_rd, imem_addr); end
    n = 0;
    while (!instr_valid_o && n < 10) begin tick(0, 0, 16'h0, 0); n++; end
    checks++; if ({instr_valid_o, instr_o} !== {1'b1, 16'h5555}) begin errors++; $display("FAIL halt_target: got v=%b %h want v=1 5555", instr_valid_o, instr_o); end
  endtask

  task automatic test_redirect_skid();
    int n;
    clear_mem();
    mem[0] = 16'h0123; mem[1] = 16'h8456; mem[16'h20] = 16'h7777;
    lat_rand = 0; lat = 1;
    do_reset();
    tick(0, 0, 16'h0, 0);
    tick(0, 0, 16'h0, 0);
    tick(0, 0, 16'h0, 0);
    tick(1, 0, 16'h0, 0);
    tick(1, 1, 16'h0020, 0);
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL rskid_no_req: got %b want 0", imem_rd); end
    tick(0, 0, 16'h0, 0);
    checks++; if ({instr_valid_o, imem_rd, imem_addr} !== {1'b0, 1'b1, 16'h0020}) begin errors++; $display("FAIL rskid_flush: got v=%b rd=%b addr=%h want 0 1 0020", instr_valid_o, imem_rd, imem_addr); end
    n = 0;
    while (!instr_valid_o && n < 10) begin tick(0, 0, 16'h0, 0); n++; end
    checks++; if ({instr_valid_o, instr_o, pc_plus1_o} !== {1'b1, 16'h7777, 16'h0021}) begin errors++; $display("FAIL rskid_target: got v=%b %h pc1=%h want v=1 7777 pc1=0021", instr_valid_o, instr_o, pc_plus1_o); end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    clear_mem();
    mem[0] = 16'h0123; mem[1] = 16'h8456;
    lat_rand = 0; lat = 3;
    do_reset();
    n = 0;
    while (!instr_valid_o && n < 20) begin tick(0, 0, 16'h0, 0); n++; end
    tick(0, 0, 16'h0, 0);
    tick(0, 0, 16'h0, 1);
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL rstw_rd: got %b want 0", imem_rd); end
    tick(0, 0, 16'h0, 0);
    checks++; if ({instr_valid_o, instr_o, pc_plus1_o, halted_o} !== {1'b0, 16'h0000, 16'h0000, 1'b0}) begin errors++; $display("FAIL rstw_outputs: got v=%b %h pc1=%h h=%b want 0 0000 0000 0", instr_valid_o, instr_o, pc_plus1_o, halted_o); end
    checks++; if ({imem_rd, imem_addr} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL rstw_req: got rd=%b addr=%h want 1 0000", imem_rd, imem_addr); end
    n = 0;
    while (!instr_valid_o && n < 20) begin tick(0, 0, 16'h0, 0); n++; end
    checks++; if ({instr_o, pc_plus1_o} !== {16'h0123, 16'h0001}) begin errors++; $display("FAIL rstw_refetch: got %h pc1=%h want 0123 0001", instr_o, pc_plus1_o); end
  endtask

  task automatic test_wrap();
    int n;
    clear_mem();
    mem[16'hFFFF] = 16'h1234; mem[0] = 16'h0123;
    lat_rand = 0; lat = 2;
    do_reset();
    tick(0, 1, 16'hFFFF, 0);
    n = 0;
    while (!instr_valid_o && n < 20) begin tick(0, 0, 16'h0, 0); n++; end
    checks++; if ({instr_valid_o, instr_o, pc_plus1_o} !== {1'b1, 16'h1234, 16'h0000}) begin errors++; $display("FAIL wrap_last: got v=%b %h pc1=%h want v=1 1234 0000", instr_valid_o, instr_o, pc_plus1_o); end
    tick(0, 0, 16'h0, 0);
    n = 0;
    while (!instr_valid_o && n < 20) begin tick(0, 0, 16'h0, 0); n++; end
    checks++; if ({instr_valid_o, instr_o, pc_plus1_o} !== {1'b1, 16'h0123, 16'h0001}) begin errors++; $display("FAIL wrap_zero: got v=%b %h pc1=%h want v=1 0123 0001", instr_valid_o, instr_o, pc_plus1_o); end
  endtask

  // Program-order model: each consumed IF/ID word must be mem[exp_pc].
  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] want;
    logic [15:0] rp;
    bit exp_halt;
    bit s;
    bit r;
    int consumed;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    lat_rand = 1;
    do_reset();
    exp_pc = 16'h0000; exp_halt = 0; consumed = 0;
    for (int c = 0; c < 4000; c++) begin
      s = ($urandom_range(99) < 25);
      r = halted_o ? ($urandom_range(99) < 20) : ($urandom_range(99) < 3);
      rp = 16'($urandom);
      tick(s, r, rp, 0);
      checks++; if (hold_viol !== 1'b0) begin errors++; $display("FAIL rnd_req_hold: cycle %0d rd=%b addr=%h want held %h", c, imem_rd, imem_addr, m_addr); end
      if (halted_o) begin
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL rnd_halt_rd: cycle %0d got %b want 0", c, imem_rd); end
      end
      if (instr_valid_o && !s && !r) begin
        checks++;
        if (exp_halt) begin
          errors++; $display("FAIL rnd_after_hlt: cycle %0d got %h want nothing", c, instr_o);
        end else begin
          want = mem[exp_pc];
          if ({instr_o, opcode_o, pc_plus1_o} !== {want, want[15:12], exp_pc + 16'h0001}) begin
            errors++;
            $display("FAIL rnd_stream: cycle %0d got %h op=%h pc1=%h want %h op=%h pc1=%h", c, instr_o, opcode_o, pc_plus1_o, want, want[15:12], exp_pc + 16'h0001);
          end
          if (want[15:12] == 4'hF) begin
            checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL rnd_hlt_flag: cycle %0d got %b want 1", c, halted_o); end
            exp_halt = 1;
          end
          exp_pc = exp_pc + 16'h0001;
          consumed++;
        end
      end
      if (r) begin exp_pc = rp; exp_halt = 0; end
    end
    checks++; if (consumed < 300) begin errors++; $display("FAIL rnd_progress: got %0d consumed want >= 300", consumed); end
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0;
    imem_valid = 1'b0; imem_data = 16'h0;
    m_busy = 0; m_cnt = 0; m_addr = 16'h0; lat = 1; lat_rand = 0; hold_viol = 0;
    clear_mem();
    test_reset();
    test_sequential();
    test_stall();
    test_squash();
    test_halt();
    test_redirect_skid();
    test_reset_mid_wait();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 16-bit WISC core. Holds the PC and fetches one 16-bit instruction at a time over a variable-latency instruction-memory handshake. Presents the instruction, its opcode nibble (consumed directly by control_unit) and PC+1 to decode. Handles hazard stalls, branch/call/ret redirects resolved downstream, and halt.

Parameters:
ADDR_W, 16, PC and instruction-memory word-address width
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous active-high reset
stall_i  input  1  hazard stall; hold IF/ID contents
redirect_i  input  1  taken branch/call/ret; load redirect_pc_i, flush IF/ID
redirect_pc_i  input  ADDR_W  redirect target
imem_rd  output  1  read request to instruction memory
imem_addr  output  ADDR_W  word address of request
imem_data  input  16  returned instruction word
imem_valid  input  1  imem_data valid this cycle (>=1 cycle after imem_rd)
instr_o  output  16  IF/ID instruction
opcode_o  output  4  instr_o[15:12], to control_unit
pc_plus1_o  output  ADDR_W  address of instr_o + 1
instr_valid_o  output  1  IF/ID holds a live instruction
halted_o  output  1  fetch stopped on HLT (opcode 4'b1111)

Behaviour:
- Reset (synchronous, any state, including mid-request): pc=RESET_PC, state=REQ, instr_o=16'h0000, pc_plus1_o=0, instr_valid_o=0, halted_o=0, imem_rd=0, skid buffer empty, squash=0. First imem_rd issues the cycle after rst falls.
- States: REQ, WAIT, HALT.
- REQ: imem_rd=1, imem_addr=pc. Next state WAIT (or accept immediately if imem_valid this same cycle is permitted? No: response is valid only >=1 cycle after request).
- WAIT: imem_rd and imem_addr held constant until imem_valid. On imem_valid: pc<=pc+1 (wraps at 2^ADDR_W-1 -> 0); word goes to IF/ID if not stalled, else into one-entry skid buffer. Next state REQ, or HALT if the accepted word's opcode is 4'b1111.
- No new request issues while the skid buffer is full; fetch resumes the cycle after the buffer drains.
- IF/ID update (stall_i=0): load from skid buffer if full, else from accepted imem_data, else instr_valid_o<=0. stall_i=1: IF/ID unchanged.
- Redirect (priority over stall and over memory response): pc<=redirect_pc_i, IF/ID instr_valid_o<=0, skid buffer cleared, halted_o<=0. If a request is outstanding (WAIT), set squash; stay in WAIT with imem_addr unchanged, discard the next imem_valid, clear squash, then REQ at new pc. Otherwise go to REQ next cycle.
- HALT: imem_rd=0, halted_o=1, pc frozen at HLT address+1; HLT word itself remains in IF/ID (or skid) and flows to decode normally. Exit only via redirect_i or rst.
- opcode_o always equals instr_o[15:12]; downstream gates all side effects with instr_valid_o.
- pc_plus1_o is the PC captured with the word (address+1), used downstream for branch target and call link.

Test Plan:
- Reset, 1-cycle memory, mem[0]=16'h0123, mem[1]=16'h8456 -> instr_o 0123, pc_plus1_o 0001, then 8456, opcode_o 4'h8, pc_plus1_o 0002; imem_addr sequence 0,1,2.
- stall_i high 3 cycles as mem[1] returns -> instr_o stays 0123; after release 8456 appears next cycle with no extra imem_rd for address 1.
- 3-cycle memory latency, redirect_i with redirect_pc_i=16'h0040 one cycle after request to address 2 -> mem[2] response dropped, next imem_addr 0040, instr_valid_o 0 until mem[0x40] arrives.
- mem[2]=16'hF000 -> F000 presented with opcode_o 4'hF, then imem_rd stays 0, halted_o 1; redirect to 16'h0010 -> halted_o 0, fetch resumes at 0010.
- redirect_i and stall_i same cycle, skid full -> skid cleared, instr_valid_o 0, redirect target fetched.
- rst asserted in WAIT with response pending -> outputs at reset values next cycle; PC=RESET_PC; first request after rst falls.
